shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 128 ++++++++++++
 tb/tb_shift_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven shift register with a small IDLE/SHIFT/DONE FSM.
//
// A command (load_val, mode, amount, serial_in) is accepted when start=1 and ready=1.
// The register is loaded, then shifted one bit per cycle 'amount' times in the latched
// direction, filling with the latched serial_in bit. Every bit ejected from the register
// is ORed into the sticky 'lost' flag. 'done' pulses for one cycle at the end.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   command valid
//   load_val   in   [WIDTH-1:0] initial register value
//   mode       in   1 = shift right, 0 = shift left
//   amount     in   [CW-1:0] number of single-bit shifts
//   serial_in  in   fill bit
//   ready      out  high in IDLE
//   busy       out  high in SHIFT and DONE
//   done       out  one-cycle completion pulse
//   out        out  [WIDTH-1:0] register contents
//   lost       out  sticky OR of ejected bits for the current command

module shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic [CW-1:0]    amount,
  input  logic             serial_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             lost
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             lost_q, lost_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             fill_q, fill_d;

  logic             accept;
  logic [WIDTH-1:0] shifted;
  logic             ejected;

  assign accept = start && (state_q == StIdle);

  // One-bit shift of the current contents using the latched direction and fill bit.
  always_comb begin
    if (mode_q) begin
      shifted = {fill_q, out_q[WIDTH-1:1]};
      ejected = out_q[0];
    end else begin
      shifted = {out_q[WIDTH-2:0], fill_q};
      ejected = out_q[WIDTH-1];
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    lost_d  = lost_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          out_d   = load_val;
          lost_d  = 1'b0;
          cnt_d   = amount;
          mode_d  = mode;
          fill_d  = serial_in;
          state_d = (amount == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        out_d  = shifted;
        lost_d = lost_q | ejected;
        cnt_d  = cnt_q - CW'(1);
        // Counter at 1 means this edge performs the last shift.
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      out_q   <= '0;
      lost_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      lost_q  <= lost_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign busy  = (state_q == StShift) || (state_q == StDone);
  assign done  = (state_q == StDone);
  assign out   = out_q;
  assign lost  = lost_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (WIDTH=4, CW=3).
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.

module tb_shift_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             mode;
  logic [CW-1:0]    amount;
  logic             serial_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             lost;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load_val (load_val),
    .mode     (mode),
    .amount   (amount),
    .serial_in(serial_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .lost     (lost)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [WIDTH-1:0] lv, input logic m, input logic [CW-1:0] amt,
                       input logic fill);
    load_val  = lv;
    mode      = m;
    amount    = amt;
    serial_in = fill;
    start     = 1'b1;
  endtask

  logic [WIDTH-1:0] over_exp [5];

  initial begin
    over_exp[0] = 4'b0001;
    over_exp[1] = 4'b0011;
    over_exp[2] = 4'b0111;
    over_exp[3] = 4'b1111;
    over_exp[4] = 4'b1111;

    reset = 1'b1; start = 1'b1; load_val = 4'b1111; mode = 1'b0; amount = 3'd2;
    serial_in = 1'b1;
    tick();
    tick();
    reset = 1'b0; start = 1'b0;
    check_eq("rst_ready", ready, 1);
    check_eq("rst_busy",  busy,  0);
    check_eq("rst_done",  done,  0);
    check_eq("rst_out",   out,   0);
    check_eq("rst_lost",  lost,  0);

    // Left shift 0011 by 2.
    issue(4'b0011, 1'b0, 3'd2, 1'b0);
    tick();
    start = 1'b0;
    check_eq("l_busy0", busy, 1);
    check_eq("l_out0",  out,  4'b0011);
    tick();
    check_eq("l_out1",  out,  4'b0110);
    check_eq("l_done1", done, 0);
    tick();
    check_eq("l_out2",  out,  4'b1100);
    check_eq("l_done2", done, 1);
    check_eq("l_lost",  lost, 0);
    tick();
    check_eq("l_done3", done, 0);
    check_eq("l_ready", ready, 1);
    check_eq("l_hold",  out,  4'b1100);

    // Idle hold: operand changes without start must not disturb anything.
    load_val = 4'b0101; mode = 1'b1; amount = 3'd7; serial_in = 1'b1;
    tick();
    tick();
    check_eq("idle_out",  out,  4'b1100);
    check_eq("idle_lost", lost, 0);
    check_eq("idle_rdy",  ready, 1);

    // Right shift 1011 by 1.
    issue(4'b1011, 1'b1, 3'd1, 1'b0);
    tick();
    start = 1'b0;
    tick();
    check_eq("r_out",  out,  4'b0101);
    check_eq("r_lost", lost, 1);
    check_eq("r_done", done, 1);
    tick();

    // Zero amount: DONE straight after accept, lost cleared.
    issue(4'b1001, 1'b0, 3'd0, 1'b0);
    tick();
    start = 1'b0;
    check_eq("z_done", done, 1);
    check_eq("z_out",  out,  4'b1001);
    check_eq("z_lost", lost, 0);
    tick();
    check_eq("z_ready", ready, 1);
    check_eq("z_done2", done,  0);

    // Over-shift: amount 5 > WIDTH, fill 1.
    issue(4'b0000, 1'b0, 3'd5, 1'b1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("o_out%0d", i + 1), out, over_exp[i]);
      check_eq($sformatf("o_done%0d", i + 1), done, (i == 4) ? 1 : 0);
      if (i == 3) check_eq("o_lost4", lost, 0);
    end
    check_eq("o_lost5", lost, 1);
    tick();

    // Back-to-back: second command pulsed during SHIFT and held through DONE.
    issue(4'b0011, 1'b0, 3'd2, 1'b0);
    tick();
    issue(4'b1111, 1'b1, 3'd1, 1'b0);
    tick();
    check_eq("b_out1", out, 4'b0110);
    tick();
    check_eq("b_out2",  out,   4'b1100);
    check_eq("b_done",  done,  1);
    check_eq("b_rdy2",  ready, 0);
    tick();
    check_eq("b_rdy3",  ready, 1);
    check_eq("b_out3",  out,   4'b1100);
    tick();
    start = 1'b0;
    check_eq("b_acc_out",  out,  4'b1111);
    check_eq("b_acc_busy", busy, 1);
    tick();
    check_eq("b2_out",  out,  4'b0111);
    check_eq("b2_lost", lost, 1);
    check_eq("b2_done", done, 1);
    tick();

    // Reset during the second SHIFT cycle of an amount=4 command.
    issue(4'b1010, 1'b0, 3'd4, 1'b0);
    tick();
    start = 1'b0;
    tick();
    check_eq("m_out1", out, 4'b0100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("m_out",   out,   4'b0000);
    check_eq("m_lost",  lost,  0);
    check_eq("m_ready", ready, 1);
    check_eq("m_busy",  busy,  0);
    check_eq("m_done",  done,  0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("m_nodone%0d", i), done, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
